alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use parameter DATA_WIDTH, default from arch_defs_pkg (8), as the operand/result width.
REQ-002 The block SHALL use one clock and SHALL have an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock shared with the ALU.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) request pending; held stable by requester until accepted.
REQ-006 reqN_ready  output  1  (N=0,1) grant; transfer on reqN_valid & reqN_ready at rising edge.
REQ-007 reqN_a, reqN_b  input  DATA_WIDTH  (N=0,1) operands A and B.
REQ-008 reqN_op  input  2  (N=0,1) operation, ALU_ADD/ALU_SUB/ALU_AND/ALU_OR encoding.
REQ-009 alu_a, alu_b  output  DATA_WIDTH  operands to ALU a_in/b_in, registered.
REQ-010 alu_op  output  2  operation to ALU alu_op, registered.
REQ-011 alu_result  input  DATA_WIDTH  ALU latched_result (valid one edge after operands applied).
REQ-012 alu_zero, alu_carry, alu_negative  input  1 each  ALU combinational flags for current operands.
REQ-013 rsp_valid  output  1  response available; held until rsp_ready.
REQ-014 rsp_ready  input  1  response consumer accepts on rsp_valid & rsp_ready at rising edge.
REQ-015 rsp_id  output  1  index of requester owning the response.
REQ-016 rsp_data  output  DATA_WIDTH  registered ALU result.
REQ-017 rsp_zero, rsp_carry, rsp_negative  output  1 each  registered flags for rsp_data.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM SHALL have states IDLE, EXEC, CAPT, RESP; one transaction in flight at a time.
REQ-020 IDLE: reqN_ready SHALL be asserted combinationally only for the arbitration winner; both low outside IDLE.
REQ-021 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last wins; last_grant SHALL update only on a completed handshake.
REQ-022 On handshake edge: SHALL load alu_a/alu_b/alu_op from winner's inputs, record owner id, go IDLE->EXEC.
REQ-023 EXEC (one cycle): at ending edge SHALL register alu_zero/alu_carry/alu_negative into rsp flags; go CAPT.
REQ-024 CAPT (one cycle): at ending edge SHALL register alu_result into rsp_data; go RESP.
REQ-025 RESP: rsp_valid SHALL be 1 and rsp_id/rsp_data/flags stable; on rsp_ready edge go IDLE, rsp_valid low next cycle.
REQ-026 Latency: handshake edge E0 -> rsp_valid high after edge E2 (third cycle); minimum throughput one op per 4 cycles.
REQ-027 New grant SHALL NOT occur in the same cycle as the RESP handshake; earliest next reqN_ready is the cycle after.
REQ-028 alu_a/alu_b/alu_op SHALL hold last transaction values in all states after EXEC until the next grant.
REQ-029 Flag semantics SHALL pass through unmodified (SUB carry=1 means no borrow; AND/OR carry=0).
REQ-030 reqN_valid deasserting without handshake SHALL have no effect; no request SHALL be lost or duplicated.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, rsp_valid=0, busy=0, reqN_ready=0 for its duration.
REQ-032 Reset values: alu_a=alu_b=0, alu_op=ALU_ADD, rsp_id=0, rsp_data=0, rsp flags=0, last_grant=1 (requester 0 wins first tie).
REQ-033 Reset mid-transaction SHALL abandon it; no response issued for it after reset release.

Verification
REQ-034 req0 ADD 0x7F,0x01, rsp_ready=1 -> rsp_valid after E2, rsp_id=0, rsp_data=0x80, N=1 Z=0 C=0.
REQ-035 req1 SUB 0x05,0x05 -> rsp_id=1, rsp_data=0x00, Z=1 C=1 N=0; req0 ADD 0xFF,0x01 -> 0x00, Z=1 C=1.
REQ-036 Both valid continuously from reset, rsp_ready=1 -> grants 0,1,0,1 spaced 4 cycles; ids match order.
REQ-037 rsp_ready low 5 cycles in RESP -> rsp outputs stable, reqN_ready both 0, no new grant until cycle after acceptance.
REQ-038 reset_n low during EXEC -> outputs at reset values before next edge; after release, req0 AND 0xF0,0x3C -> 0x30, Z=0 C=0 N=0.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: datapath width and ALU operation encoding.
package arch_defs_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned OP_WIDTH   = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bus bundle for alu_arbiter: two request channels, the ALU operand/result
// channel and the response channel.
//   slave  : arbiter view (requests/ALU results in, grants/operands/response out)
//   master : environment view (requesters, ALU and response consumer)
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
);

    localparam int unsigned OW = arch_defs_pkg::OP_WIDTH;

    // Requester 0
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic [OW-1:0]         req0_op;

    // Requester 1
    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic [OW-1:0]         req1_op;

    // ALU side
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [OW-1:0]         alu_op;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_zero;
    logic                  alu_carry;
    logic                  alu_negative;

    // Response side
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_zero;
    logic                  rsp_carry;
    logic                  rsp_negative;

    // Status
    logic                  busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero, alu_carry, alu_negative,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry, rsp_negative,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero, alu_carry, alu_negative,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry, rsp_negative,
        input  busy
    );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters. One transaction
// is in flight at a time: grant in IDLE, flags captured after EXEC, result
// captured after CAPT, response held in RESP until accepted.
// Ports:
//   clk     : rising-edge clock shared with the ALU
//   reset_n : asynchronous active-low reset
//   bus     : alu_arbiter_if.slave (requests, ALU channel, response, busy)
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);

    localparam int unsigned OW = arch_defs_pkg::OP_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e                state_q;
    state_e                state_d;
    logic                  last_grant_q;
    logic                  winner_c;
    logic                  grant_c;
    logic [DATA_WIDTH-1:0] win_a;
    logic [DATA_WIDTH-1:0] win_b;
    logic [OW-1:0]         win_op;

    // Round-robin pick: on a tie the requester not granted last wins.
    always_comb begin
        winner_c = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            winner_c = ~last_grant_q;
        end
    end

    assign win_a  = winner_c ? bus.req1_a  : bus.req0_a;
    assign win_b  = winner_c ? bus.req1_b  : bus.req0_b;
    assign win_op = winner_c ? bus.req1_op : bus.req0_op;

    // Next-state and grant decode.
    always_comb begin
        state_d = state_q;
        grant_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    grant_c = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are combinational; masked by reset so nothing is granted while held.
    assign bus.req0_ready = grant_c & reset_n & ~winner_c;
    assign bus.req1_ready = grant_c & reset_n &  winner_c;

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bus.rsp_valid <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus.rsp_valid <= (state_d == RESP);
            bus.busy      <= (state_d != IDLE);
        end
    end

    // Operand launch on grant, flag capture after EXEC, result capture after CAPT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.alu_a        <= '0;
            bus.alu_b        <= '0;
            bus.alu_op       <= arch_defs_pkg::ALU_ADD;
            bus.rsp_id       <= 1'b0;
            bus.rsp_data     <= '0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_carry    <= 1'b0;
            bus.rsp_negative <= 1'b0;
            last_grant_q     <= 1'b1;
        end else begin
            if (grant_c) begin
                bus.alu_a    <= win_a;
                bus.alu_b    <= win_b;
                bus.alu_op   <= win_op;
                bus.rsp_id   <= winner_c;
                last_grant_q <= winner_c;
            end
            if (state_q == EXEC) begin
                bus.rsp_zero     <= bus.alu_zero;
                bus.rsp_carry    <= bus.alu_carry;
                bus.rsp_negative <= bus.alu_negative;
            end
            if (state_q == CAPT) begin
                bus.rsp_data <= bus.alu_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a behavioural ALU
// (combinational flags, result latched one edge after operands).
module tb_alu_arbiter;

    import arch_defs_pkg::*;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    alu_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Behavioural ALU
    logic [8:0] alu_sum;
    always_comb begin
        case (bus.alu_op)
            2'd0:    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            2'd1:    alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
            2'd2:    alu_sum = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_sum = {1'b0, bus.alu_a | bus.alu_b};
        endcase
        bus.alu_zero     = (alu_sum[7:0] == 8'h00);
        bus.alu_carry    = alu_sum[8];
        bus.alu_negative = alu_sum[7];
    end

    always @(posedge clk) bus.alu_result <= alu_sum[7:0];

    int n_checks = 0;
    int n_fail   = 0;

    int         g_id  [4];
    int         g_cyc [4];
    int         r_id  [4];
    logic [7:0] r_dat [4];
    int         ng = 0;
    int         nr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_req(input bit id, input logic [1:0] op, input logic [7:0] a,
                             input logic [7:0] b, input bit valid);
        if (id) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = valid;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = valid;
        end
    endtask

    // Returns at a negedge with the requested grant visible, or times out.
    task automatic wait_ready(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? bus.req1_ready : bus.req0_ready) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    // Counts negedges without rsp_valid; returns at the first negedge with it.
    task automatic wait_rsp(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                ok = 1'b1;
                return;
            end
            lat++;
        end
    endtask

    // One full transaction with rsp_ready held high; entered/left at posedge+1.
    task automatic run_txn(input string tag, input bit id, input logic [1:0] op,
                           input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_d,
                           input bit ez, input bit ec, input bit en);
        bit ok;
        int lat;
        drive_req(id, op, a, b, 1'b1);
        wait_ready(id, ok);
        check({tag, "_grant"}, 32'(ok), 32'd1);
        if (!ok) begin
            drive_req(id, op, a, b, 1'b0);
            return;
        end
        check({tag, "_other_ready"}, 32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        drive_req(id, op, a, b, 1'b0);
        wait_rsp(lat, ok);
        check({tag, "_latency"}, ok ? 32'(lat) : 32'hFFFF_FFFF, 32'd2);
        check({tag, "_id"},    32'(bus.rsp_id),   32'(id));
        check({tag, "_data"},  32'(bus.rsp_data), 32'(exp_d));
        check({tag, "_flags"}, 32'({bus.rsp_zero, bus.rsp_carry, bus.rsp_negative}),
              32'({ez, ec, en}));
        check({tag, "_alu_hold"}, 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'({op, a, b}));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done"}, 32'({bus.rsp_valid, bus.busy}), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        check({tag, "_status"}, 32'({bus.rsp_valid, bus.busy}), 32'd0);
        check({tag, "_alu"},    32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
        check({tag, "_rsp"},    32'({bus.rsp_id, bus.rsp_data}), 32'd0);
        check({tag, "_flags"},  32'({bus.rsp_zero, bus.rsp_carry, bus.rsp_negative}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit ok;
        int lat;

        // Reset with both requesters already pending
        reset_n       = 1'b0;
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, ALU_ADD, 8'h10, 8'h20, 1'b1);
        drive_req(1'b1, ALU_SUB, 8'h20, 8'h10, 1'b1);
        repeat (3) @(negedge clk);
        check_reset_vals("reset");

        // Round-robin with both valid continuously
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 60 && nr < 4; cyc++) begin
            @(negedge clk);
            if (ng < 4 && (bus.req0_ready || bus.req1_ready)) begin
                g_id[ng]  = bus.req1_ready ? 1 : 0;
                g_cyc[ng] = cyc;
                ng++;
            end
            if (bus.rsp_valid && bus.rsp_ready && nr < 4) begin
                r_id[nr]  = bus.rsp_id ? 1 : 0;
                r_dat[nr] = bus.rsp_data;
                nr++;
            end
            @(posedge clk); #1;
            if (ng == 4) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end
        check("rr_grant_count", 32'(ng), 32'd4);
        check("rr_rsp_count",   32'(nr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rr_grant%0d_id", k), 32'(g_id[k]), 32'(k % 2));
            check($sformatf("rr_rsp%0d_id", k),   32'(r_id[k]), 32'(k % 2));
            check($sformatf("rr_rsp%0d_data", k), 32'(r_dat[k]),
                  (k % 2 == 1) ? 32'h10 : 32'h30);
            if (k > 0) begin
                check($sformatf("rr_spacing%0d", k), 32'(g_cyc[k] - g_cyc[k-1]), 32'd4);
            end
        end

        // Single-requester transactions with hand-computed results
        run_txn("add_7f_01", 1'b0, ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        run_txn("sub_05_05", 1'b1, ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
        run_txn("add_ff_01", 1'b0, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        run_txn("or_0f_80",  1'b1, ALU_OR,  8'h0F, 8'h80, 8'h8F, 1'b0, 1'b0, 1'b1);
        run_txn("sub_03_05", 1'b0, ALU_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b1);

        // Back-pressure: response held for 5 cycles with another request pending
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, ALU_OR, 8'h55, 8'hAA, 1'b1);
        wait_ready(1'b1, ok);
        check("bp_grant", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        drive_req(1'b0, ALU_ADD, 8'h01, 8'h02, 1'b1);
        wait_rsp(lat, ok);
        check("bp_rsp", 32'(ok), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("bp_hold%0d", i),
                  32'({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.busy,
                       bus.req0_ready, bus.req1_ready}),
                  32'({1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0}));
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_accept_no_grant", 32'({bus.rsp_valid, bus.req0_ready}), 32'b10);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_next_grant", 32'({bus.rsp_valid, bus.req0_ready}), 32'b01);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        wait_rsp(lat, ok);
        check("bp_second_latency", ok ? 32'(lat) : 32'hFFFF_FFFF, 32'd2);
        check("bp_second_rsp", 32'({bus.rsp_id, bus.rsp_data}), 32'({1'b0, 8'h03}));
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset during EXEC abandons the transaction
        drive_req(1'b1, ALU_ADD, 8'h11, 8'h22, 1'b1);
        wait_ready(1'b1, ok);
        check("abort_grant", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort_reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort_quiet%0d", i), 32'({bus.rsp_valid, bus.busy}), 32'd0);
        end
        @(posedge clk); #1;
        run_txn("and_f0_3c", 1'b0, ALU_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
